regfile_dump: RTL and testbench

Debug read-out engine for the 15-entry processor register file. On a start pulse it walks a register range through a dedicated register-file read port. It captures each 32-bit value and presents it, tagged with its index, on a valid/ready output stream to the debug/trace logic. It sits beside the register file on the opposite side from the write-back path: write-back writes, this block reads. Its reads never disturb the pipeline's own read ports.

---
 rtl/regfile_dump.sv | 163 ++++++++++++++++
 tb/tb_regfile_dump.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// regfile_dump
//   Debug read-out engine for the processor register file. A start pulse
//   walks first_reg..last_reg through a dedicated asynchronous read port.
//   Each value is captured and offered, tagged with its index, on a
//   valid/ready output stream.
//
//   Output handshake: a word transfers at a rising edge where
//   out_valid && out_ready. Once raised, out_valid, out_data and out_idx
//   hold steady until that transfer, or until abort/reset drops them.
//
// Ports
//   clk, rst              clock, synchronous active-low reset
//   start                 one-cycle dump request (accepted only when idle)
//   first_reg, last_reg   inclusive range, sampled with start
//   abort                 terminates a dump in progress
//   rd_addr / rd_data     register-file read port (data is combinational)
//   out_valid/out_ready   output stream handshake
//   out_data, out_idx     captured value and its register index
//   busy                  dump in progress
//   done                  one-cycle pulse at the end of every dump
//   err, aborted          qualify done: illegal range / aborted dump
//   count                 words delivered in the current or last dump
module regfile_dump #(
    parameter int NUM_REGS = 15,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              aborted,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] last_q;
    logic              range_ok;
    logic              handshake;
    logic              last_word;

    // Range check is made on the live inputs, since it is only consulted
    // in the cycle start is accepted.
    assign range_ok  = (first_reg <= last_reg) && ({1'b0, last_reg} < NUM_REGS_L);
    assign handshake = out_valid && out_ready;
    assign last_word = (out_idx == last_q);

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start && range_ok) state_nx = READ;
            end
            READ: begin
                state_nx = abort ? IDLE : HOLD;
            end
            HOLD: begin
                // abort wins over a simultaneous handshake
                if (abort)          state_nx = IDLE;
                else if (handshake) state_nx = last_word ? IDLE : READ;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Datapath and status registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            aborted   <= 1'b0;
            count     <= '0;
            last_q    <= '0;
        end else begin
            // done and its qualifiers are single-cycle pulses
            done    <= 1'b0;
            err     <= 1'b0;
            aborted <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        last_q <= last_reg;
                        count  <= '0;
                        if (range_ok) begin
                            rd_addr <= first_reg;
                            busy    <= 1'b1;
                        end else begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        aborted   <= 1'b1;
                        rd_addr   <= '0;
                    end else begin
                        out_data  <= rd_data;
                        out_idx   <= rd_addr;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (abort) begin
                        // the word on offer is dropped and not counted
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        aborted   <= 1'b1;
                        rd_addr   <= '0;
                    end else if (handshake) begin
                        out_valid <= 1'b0;
                        count     <= count + 1'b1;
                        if (last_word) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            rd_addr <= '0;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump
//   Directed bench for regfile_dump. Models a 15-entry register file with a
//   combinational read port and falling-edge writes, records every word
//   transferred on the output stream, and compares against hand-computed
//   expected values through one checking task.
module tb_regfile_dump;

    localparam int NUM_REGS = 15;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] first_reg;
    logic [ADDR_W-1:0] last_reg;
    logic              abort;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              busy;
    logic              done;
    logic              err;
    logic              aborted;
    logic [ADDR_W:0]   count;

    logic [DATA_W-1:0] regfile [NUM_REGS];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // monitor records
    logic [DATA_W-1:0] got_data[$];
    logic [ADDR_W-1:0] got_idx[$];
    int                got_cyc[$];
    int                done_cnt;
    int                err_cnt;
    int                abort_cnt;
    logic              busy_seen;
    logic              valid_seen;

    regfile_dump #(
        .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .first_reg(first_reg),
        .last_reg(last_reg), .abort(abort), .rd_addr(rd_addr),
        .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .busy(busy), .done(done),
        .err(err), .aborted(aborted), .count(count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // asynchronous read port
    always_comb begin
        rd_data = '0;
        if (int'(rd_addr) < NUM_REGS) rd_data = regfile[rd_addr];
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- monitor (samples on falling edge) ----------------
    logic              prev_valid;
    logic              prev_ready;
    logic [DATA_W-1:0] prev_data;
    logic [ADDR_W-1:0] prev_idx;

    initial begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_data  = '0;
        prev_idx   = '0;
    end

    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready && !abort) begin
                got_data.push_back(out_data);
                got_idx.push_back(out_idx);
                got_cyc.push_back(cyc);
            end
            if (prev_valid && !prev_ready && out_valid) begin
                check("hold_data", out_data, prev_data);
                check("hold_idx", 32'(out_idx), 32'(prev_idx));
            end
            if (done) begin
                done_cnt++;
                if (err)     err_cnt++;
                if (aborted) abort_cnt++;
            end
            if (busy)      busy_seen = 1'b1;
            if (out_valid) valid_seen = 1'b1;
        end
        prev_valid = out_valid && rst;
        prev_ready = out_ready;
        prev_data  = out_data;
        prev_idx   = out_idx;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_records();
        got_data.delete();
        got_idx.delete();
        got_cyc.delete();
        done_cnt   = 0;
        err_cnt    = 0;
        abort_cnt  = 0;
        busy_seen  = 1'b0;
        valid_seen = 1'b0;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l);
        start     = 1'b1;
        first_reg = f;
        last_reg  = l;
        step();
        start = 1'b0;
    endtask

    // ready_mode 0: out_ready always 1; 1: out_ready high one cycle in three
    task automatic run_dump(input int ready_mode, input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            out_ready = (ready_mode == 0) ? 1'b1 : (cycles % 3 == 2);
            step();
            cycles++;
        end
        check("done_within_budget", 32'(done), 32'd1);
        out_ready = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  out_data,       32'd0);
        check({tag, "_out_idx"},   32'(out_idx),   32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_err"},       32'(err),       32'd0);
        check({tag, "_aborted"},   32'(aborted),   32'd0);
        check({tag, "_count"},     32'(count),     32'd0);
    endtask

    // ---------------- stimulus ----------------
    int cycles;

    initial begin
        for (int j = 0; j < NUM_REGS; j++) regfile[j] = 32'(j);
        rst       = 1'b0;
        start     = 1'b0;
        first_reg = '0;
        last_reg  = '0;
        abort     = 1'b0;
        out_ready = 1'b1;
        clear_records();

        // reset state
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b1;
        step();

        // full dump 0..14, out_ready held high
        clear_records();
        pulse_start(4'd0, 4'd14);
        check("full_busy_at_start", 32'(busy), 32'd1);
        check("full_rd_addr_start", 32'(rd_addr), 32'd0);
        check("full_no_valid_yet", 32'(out_valid), 32'd0);
        run_dump(0, 40, cycles);
        check("full_done_latency", 32'(cycles), 32'd30);
        check("full_busy_low_at_done", 32'(busy), 32'd0);
        check("full_done_err", 32'(err), 32'd0);
        check("full_done_aborted", 32'(aborted), 32'd0);
        check("full_rd_addr_end", 32'(rd_addr), 32'd0);
        check("full_word_count", 32'(got_idx.size()), 32'd15);
        for (int k = 0; k < got_idx.size() && k < 15; k++) begin
            check("full_idx", 32'(got_idx[k]), 32'(k));
            check("full_data", got_data[k], 32'(k));
            if (k > 0) check("full_spacing", 32'(got_cyc[k] - got_cyc[k-1]), 32'd2);
        end
        check("full_count", 32'(count), 32'd15);
        step();
        check("full_done_one_cycle", 32'(done), 32'd0);
        check("full_done_pulses", 32'(done_cnt), 32'd1);
        check("full_count_held", 32'(count), 32'd15);

        // range 3..5 with out_ready high one cycle in three
        clear_records();
        pulse_start(4'd3, 4'd5);
        run_dump(1, 60, cycles);
        check("slow_word_count", 32'(got_idx.size()), 32'd3);
        for (int k = 0; k < got_idx.size() && k < 3; k++) begin
            check("slow_idx", 32'(got_idx[k]), 32'(k + 3));
            check("slow_data", got_data[k], 32'(k + 3));
        end
        check("slow_count", 32'(count), 32'd3);
        step();
        check("slow_done_pulses", 32'(done_cnt), 32'd1);

        // illegal ranges: first>last, then last beyond the file
        clear_records();
        pulse_start(4'd7, 4'd2);
        check("ill1_done", 32'(done), 32'd1);
        check("ill1_err", 32'(err), 32'd1);
        check("ill1_aborted", 32'(aborted), 32'd0);
        check("ill1_busy", 32'(busy), 32'd0);
        check("ill1_count_cleared", 32'(count), 32'd0);
        step();
        check("ill1_done_one_cycle", 32'(done), 32'd0);
        check("ill1_err_one_cycle", 32'(err), 32'd0);
        pulse_start(4'd0, 4'd15);
        check("ill2_done", 32'(done), 32'd1);
        check("ill2_err", 32'(err), 32'd1);
        check("ill2_busy", 32'(busy), 32'd0);
        step();
        step();
        check("ill_err_pulses", 32'(err_cnt), 32'd2);
        check("ill_busy_never", 32'(busy_seen), 32'd0);
        check("ill_valid_never", 32'(valid_seen), 32'd0);

        // abort in HOLD of the 3rd word, with out_ready high in that cycle
        clear_records();
        out_ready = 1'b1;
        pulse_start(4'd0, 4'd14);
        for (int k = 0; k < 5; k++) step();
        check("abort_pre_valid", 32'(out_valid), 32'd1);
        check("abort_pre_idx", 32'(out_idx), 32'd2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_done", 32'(done), 32'd1);
        check("abort_aborted", 32'(aborted), 32'd1);
        check("abort_err", 32'(err), 32'd0);
        check("abort_count", 32'(count), 32'd2);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd_addr", 32'(rd_addr), 32'd0);
        step();
        check("abort_done_one_cycle", 32'(done), 32'd0);
        check("abort_flag_one_cycle", 32'(aborted), 32'd0);
        check("abort_words", 32'(got_idx.size()), 32'd2);
        // idle abort has no effect, then a fresh dump runs normally
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("idle_abort_no_done", 32'(done), 32'd0);
        clear_records();
        pulse_start(4'd2, 4'd3);
        run_dump(0, 20, cycles);
        check("after_abort_latency", 32'(cycles), 32'd4);
        check("after_abort_words", 32'(got_idx.size()), 32'd2);
        if (got_idx.size() == 2) begin
            check("after_abort_idx0", 32'(got_idx[0]), 32'd2);
            check("after_abort_idx1", 32'(got_idx[1]), 32'd3);
        end
        check("after_abort_count", 32'(count), 32'd2);
        step();

        // write-back to r5 while it is being read; mid-dump start ignored
        clear_records();
        pulse_start(4'd0, 4'd14);
        cycles = 0;
        while (rd_addr != 4'd5 && cycles < 20) begin
            step();
            cycles++;
        end
        check("wb_reached_r5", 32'(rd_addr), 32'd5);
        @(negedge clk);
        regfile[5] = 32'hDEAD_BEEF;
        step();
        start     = 1'b1;
        first_reg = 4'd9;
        last_reg  = 4'd9;
        step();
        start = 1'b0;
        run_dump(0, 40, cycles);
        check("wb_word_count", 32'(got_idx.size()), 32'd15);
        for (int k = 0; k < got_idx.size() && k < 15; k++) begin
            check("wb_idx", 32'(got_idx[k]), 32'(k));
            check("wb_data", got_data[k], (k == 5) ? 32'hDEAD_BEEF : 32'(k));
        end
        check("wb_count", 32'(count), 32'd15);
        step();
        check("wb_done_pulses", 32'(done_cnt), 32'd1);
        regfile[5] = 32'd5;

        // reset in HOLD of word 4, then a single-word dump
        clear_records();
        pulse_start(4'd0, 4'd14);
        for (int k = 0; k < 7; k++) step();
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        check("rst_pre_idx", 32'(out_idx), 32'd3);
        rst = 1'b0;
        step();
        check_reset_outputs("midrst");
        rst = 1'b1;
        step();
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        clear_records();
        pulse_start(4'd0, 4'd0);
        run_dump(0, 10, cycles);
        check("single_latency", 32'(cycles), 32'd2);
        check("single_words", 32'(got_idx.size()), 32'd1);
        if (got_idx.size() == 1) begin
            check("single_idx", 32'(got_idx[0]), 32'd0);
            check("single_data", got_data[0], 32'd0);
        end
        check("single_count", 32'(count), 32'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
